ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device transmit controller for the PS/2 port. It accepts one command byte through a valid/ready handshake, then runs the PS/2 request-to-send sequence on the open-drain clock and data lines: inhibit, start, 8 data bits, odd parity, stop, and device ACK. It reports completion, NACK or timeout as one-cycle pulses. It sits beside the keyboard receive path in the PS/2 peripheral, and `busy_o` tells that receive path to ignore line activity while a transmission is in progress.

## Interface
- `INHIBIT_CYC`, default 5000: cycles the clock line is held low before the request-to-send (100 µs at 50 MHz); must be ≥ 2.
- `TIMEOUT_CYC`, default 750000: maximum cycles from clock release to the ACK sample (15 ms at 50 MHz).
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `en_i` in 1: block enable; deasserting it aborts any transfer.
- `tx_valid_i` in 1: command byte valid.
- `tx_data_i` in 8: command byte.
- `tx_ready_o` out 1: byte accepted when `tx_valid_i & tx_ready_o`.
- `busy_o` out 1: a transfer is in progress (state ≠ IDLE).
- `done_o` out 1: one-cycle pulse; the device ACKed and the bus has returned to idle.
- `nack_o` out 1: one-cycle pulse; the device did not ACK.
- `tmo_o` out 1: one-cycle pulse; the timeout expired.
- `ps2_clk_i` in 1: raw PS/2 clock pin (asynchronous).
- `ps2_dat_i` in 1: raw PS/2 data pin (asynchronous).
- `ps2_clk_oe_o` out 1: 1 pulls the clock line low.
- `ps2_dat_oe_o` out 1: 1 pulls the data line low.

## Operation
- Pin conditioning: each pin passes through a 2-flop synchronizer. The clock falling edge is detected as a 1-cycle pulse `fe`.
- The FSM has these states: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
- **IDLE:** `tx_ready_o = en_i`. On accept, latch `tx_data_i` and compute parity = `~^tx_data_i`, load the timer with `INHIBIT_CYC-1`, and go to INHIBIT.
- **INHIBIT:** `clk_oe=1`, `dat_oe=0`. When the timer reaches 0, go to RTS.
- **RTS** (1 cycle): `clk_oe=1`, `dat_oe=1` (start bit). Load the timer with `TIMEOUT_CYC-1`, clear the bit counter, and go to SEND.
- **SEND:** `clk_oe=0`. On each `fe`, increment the bit counter (0..10) and update data:
  - Falls 1–8 drive data bit 0–7 (LSB first), with `dat_oe = ~bit`.
  - Fall 9 drives parity.
  - Fall 10 releases data (stop bit, `dat_oe=0`) and moves to ACK.
- **ACK:** on the next `fe`, sample synchronized data.
  - 0: go to WAIT_IDLE.
  - 1: pulse `nack_o` and go to IDLE.
- **WAIT_IDLE:** wait until the synchronized clock and data are both 1. Then pulse `done_o` and go to IDLE.
- **Timeout:** the timer decrements in SEND and ACK. On reaching 0 before the ACK sample, release both lines, pulse `tmo_o`, and go to IDLE. WAIT_IDLE is not timed.
- **Abort:** `en_i=0` in any non-IDLE state releases both lines and returns to IDLE in the next cycle, with no status pulse.
- Ignored events:
  - `fe` in IDLE, INHIBIT, RTS or WAIT_IDLE.
  - `tx_valid_i` while busy (`tx_ready_o=0`).

## Timing
- **Reset values:** state IDLE; `ps2_clk_oe_o`, `ps2_dat_oe_o`, `busy_o`, `done_o`, `nack_o` and `tmo_o` all 0; `tx_ready_o` follows `en_i`.
- **Reset mid-transfer:** both lines are released immediately (asynchronously) and no pulse is emitted.
- **Outputs:** `ps2_clk_oe_o`, `ps2_dat_oe_o` and the status pulses are registered outputs.
- **Start of transfer:** `clk_oe` rises in the cycle after accept and stays high for exactly `INHIBIT_CYC` cycles, followed by 1 RTS cycle with both OEs high.
- **Edge latency:** `fe` asserts 2 cycles after the clock pin falls (synchronizer depth). `dat_oe` updates in the cycle after `fe`.
- **Back-to-back transfers:** a new byte can be accepted in the cycle after `done_o`, `nack_o` or `tmo_o`. Minimum gap is 1 cycle.
- **Simultaneous events:** if timeout expiry and the ACK-sampling `fe` occur in the same cycle, the ACK sample wins and `tmo_o` is not asserted.
- **Widths:**
  - Timer width is `$clog2(max(INHIBIT_CYC, TIMEOUT_CYC))`.
  - The bit counter is 4 bits and saturates logic at 10 (no wrap).

## Structure
- Shared package `ps2_pkg`: the state enum `ps2_tx_state_e` and localparams for the last data fall (8), parity fall (9) and stop fall (10).
- Pin conditioning reuses the existing `edge_det_fe` (2 stages) for the clock and a plain 2-flop synchronizer for data.
- One natural sub-module: `ps2_tx_timer`, a loadable down-counter with a zero flag, shared between the inhibit and timeout phases.

## Test plan
- **Basic send, ACK:** `INHIBIT_CYC=8`. Send 0xED with a device model that ACKs.
  - `clk_oe` is high for 8 cycles, then 1 RTS cycle.
  - Bits on data are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK sampled as 0, then `done_o` pulses once.
- **Parity:** send 0x01 → parity bit 0. Send 0x00 → parity bit 1.
- **NACK:** the device leaves data high at the 11th fall → `nack_o` pulses, lines released, `tx_ready_o=1` next cycle.
- **Timeout:** `TIMEOUT_CYC=200`. The device stops clocking after 4 falls → `tmo_o` at cycle 200 after RTS, both OEs 0.
- **Abort and reset:**
  - Drop `en_i` during SEND → idle next cycle, no pulses.
  - Assert `rst_i` mid-INHIBIT → OEs 0 immediately.
- **Busy handling:** hold `tx_valid_i` with 0xAA through a transfer of 0xF4 → 0xAA is accepted only after `done_o`, and the receive-ignore signal `busy_o` is high throughout the 0xF4 transfer.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states,
// frame fall indices and the odd-parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_e;

   // Clock-fall index (1-based) at which each frame field is driven
   localparam logic [3:0] LAST_DATA_FALL = 4'd8;
   localparam logic [3:0] PARITY_FALL    = 4'd9;
   localparam logic [3:0] STOP_FALL      = 4'd10;

   function automatic logic oddParity(input logic [7:0] value);
      return ~^value;
   endfunction

endpackage

// File: rtl/edge_det_fe.sv
// Synchronizer for an asynchronous pin with a one-cycle falling-edge pulse.
// Flops reset to 1 because the PS/2 lines idle high.
module edge_det_fe #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic sync_o,
   output logic fe_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign sync_o = sync_q[STAGES-1];
   assign fe_o   = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_tx_timer.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module ps2_tx_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] loadVal_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = loadVal_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop and device ACK on the open-drain clock/data lines.
module ps2_host_tx #(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 750000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       tx_valid_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       nack_o,
   output logic       tmo_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o
);
   import ps2_pkg::*;

   localparam int MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int TW      = $clog2(MAX_CYC);

   ps2_tx_state_e state_q;
   logic [7:0]    shift_q;
   logic          parity_q;
   logic [3:0]    bitCnt_q, bitCnt_d;
   logic          clkOe_q, datOe_q, done_q, nack_q, tmo_q;
   logic [1:0]    datSync_q;
   logic          clkSync, clkFe, datSync;
   logic          accept;
   logic          timerLoad, timerDec, timerZero;
   logic [TW-1:0] timerLoadVal;

   edge_det_fe #(.STAGES(2)) u_clkSync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (ps2_clk_i),
      .sync_o (clkSync),
      .fe_o   (clkFe)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         datSync_q <= 2'b11;
      end else begin
         datSync_q <= {datSync_q[0], ps2_dat_i};
      end
   end
   assign datSync = datSync_q[1];

   assign accept   = (state_q == ST_IDLE) && en_i && tx_valid_i;
   assign bitCnt_d = (bitCnt_q == STOP_FALL) ? bitCnt_q : bitCnt_q + 4'd1;

   // One timer serves both the inhibit hold and the frame timeout
   always_comb begin
      timerLoad    = 1'b0;
      timerDec     = 1'b0;
      timerLoadVal = '0;
      case (state_q)
         ST_IDLE: begin
            timerLoad    = accept;
            timerLoadVal = TW'(INHIBIT_CYC - 1);
         end
         ST_RTS: begin
            timerLoad    = 1'b1;
            timerLoadVal = TW'(TIMEOUT_CYC - 1);
         end
         ST_INHIBIT, ST_SEND, ST_ACK: timerDec = 1'b1;
         default: ;
      endcase
   end

   ps2_tx_timer #(.W(TW)) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (timerLoad),
      .loadVal_i (timerLoadVal),
      .dec_i     (timerDec),
      .zero_o    (timerZero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         bitCnt_q <= '0;
         clkOe_q  <= 1'b0;
         datOe_q  <= 1'b0;
         done_q   <= 1'b0;
         nack_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         nack_q <= 1'b0;
         tmo_q  <= 1'b0;
         if (!en_i && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            clkOe_q <= 1'b0;
            datOe_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept) begin
                     shift_q  <= tx_data_i;
                     parity_q <= oddParity(tx_data_i);
                     clkOe_q  <= 1'b1;
                     datOe_q  <= 1'b0;
                     state_q  <= ST_INHIBIT;
                  end
               end
               ST_INHIBIT: begin
                  if (timerZero) begin
                     datOe_q <= 1'b1;
                     state_q <= ST_RTS;
                  end
               end
               ST_RTS: begin
                  clkOe_q  <= 1'b0;
                  bitCnt_q <= '0;
                  state_q  <= ST_SEND;
               end
               ST_SEND: begin
                  if (timerZero) begin
                     clkOe_q <= 1'b0;
                     datOe_q <= 1'b0;
                     tmo_q   <= 1'b1;
                     state_q <= ST_IDLE;
                  end else if (clkFe) begin
                     bitCnt_q <= bitCnt_d;
                     if (bitCnt_d <= LAST_DATA_FALL) begin
                        datOe_q <= ~shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                     end else if (bitCnt_d == PARITY_FALL) begin
                        datOe_q <= ~parity_q;
                     end else begin
                        datOe_q <= 1'b0;
                        state_q <= ST_ACK;
                     end
                  end
               end
               // The ACK sample takes priority over a timeout in the same cycle
               ST_ACK: begin
                  if (clkFe) begin
                     if (datSync) begin
                        nack_q  <= 1'b1;
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_WAIT_IDLE;
                     end
                  end else if (timerZero) begin
                     clkOe_q <= 1'b0;
                     datOe_q <= 1'b0;
                     tmo_q   <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  if (clkSync && datSync) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign tx_ready_o   = en_i && (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = done_q;
   assign nack_o       = nack_q;
   assign tmo_o        = tmo_q;
   assign ps2_clk_oe_o = clkOe_q;
   assign ps2_dat_oe_o = datOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out of the host
// and checks each line bit against a scoreboard filled when a byte is accepted.
module tb_ps2_host_tx;

   localparam int INHIBIT = 8;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 6;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic       enable  = 1'b1;
   logic       txValid = 1'b0;
   logic [7:0] txData  = 8'h00;
   logic       txReady, busy, done, nack, tmo, clkOe, datOe;
   logic       devClk = 1'b1;
   logic       devDat = 1'b1;
   logic       ps2Clk, ps2Dat;

   // Open-drain wired-AND of host and device
   assign ps2Clk = devClk & ~clkOe;
   assign ps2Dat = devDat & ~datOe;

   always #5 clock = ~clock;

   ps2_host_tx #(.INHIBIT_CYC(INHIBIT), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk_i        (clock),
      .rst_i        (reset),
      .en_i         (enable),
      .tx_valid_i   (txValid),
      .tx_data_i    (txData),
      .tx_ready_o   (txReady),
      .busy_o       (busy),
      .done_o       (done),
      .nack_o       (nack),
      .tmo_o        (tmo),
      .ps2_clk_i    (ps2Clk),
      .ps2_dat_i    (ps2Dat),
      .ps2_clk_oe_o (clkOe),
      .ps2_dat_oe_o (datOe)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   logic expBits[$];

   int   cycle = 0, doneCnt = 0, nackCnt = 0, tmoCnt = 0, longPulse = 0;
   int   rtsCycle = -1, tmoCycle = -1;
   logic prevDone = 1'b0, prevNack = 1'b0, prevTmo = 1'b0;
   logic [2:0] afterNack = 3'b000, afterTmo = 3'b000;
   logic monBusy = 1'b0;
   int   busyDrop = 0, readyEarly = 0;

   // Pulse counting and per-cycle observations, sampled on the falling edge
   always @(negedge clock) begin
      cycle++;
      if (done) doneCnt++;
      if (nack) nackCnt++;
      if (tmo)  tmoCnt++;
      if ((done && prevDone) || (nack && prevNack) || (tmo && prevTmo)) longPulse++;
      if (prevNack) afterNack = {txReady, clkOe, datOe};
      if (prevTmo)  afterTmo  = {txReady, clkOe, datOe};
      if (clkOe && datOe) rtsCycle = cycle;
      if (tmo) tmoCycle = cycle;
      if (monBusy && !done) begin
         if (!busy)   busyDrop++;
         if (txReady) readyEarly++;
      end
      prevDone = done;
      prevNack = nack;
      prevTmo  = tmo;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pushFrame(input logic [7:0] value);
      expBits.push_back(1'b0);
      for (int i = 0; i < 8; i++) expBits.push_back(value[i]);
      expBits.push_back(~^value);
      expBits.push_back(1'b1);
   endtask

   task automatic applyStimulus(input logic [7:0] value);
      int k = 0;
      @(negedge clock);
      while (!txReady && k < 2000) begin
         @(negedge clock);
         k++;
      end
      checkOutput("ready_before_send", txReady, 1);
      txValid = 1'b1;
      txData  = value;
      @(posedge clock);
      pushFrame(value);
      #1 txValid = 1'b0;
   endtask

   // Called just after the accepting edge: inhibit length, then one RTS cycle
   task automatic checkInhibit(input string tag);
      int cnt = 0;
      @(negedge clock);
      while (clkOe && !datOe && cnt < 100) begin
         cnt++;
         @(negedge clock);
      end
      checkOutput({tag, "_inhibit_len"}, cnt, INHIBIT);
      checkOutput({tag, "_rts_oe"}, {clkOe, datOe}, 2'b11);
      @(negedge clock);
      checkOutput({tag, "_start_oe"}, {clkOe, datOe}, 2'b01);
   endtask

   // Device model: samples data just before each fall; pulls data low before
   // the 11th fall when acknowledging
   task automatic runDevice(input string tag, input int nFalls, input logic doAck);
      int   k = 0;
      logic e;
      while (!(busy && !clkOe) && k < 200) begin
         @(negedge clock);
         k++;
      end
      waitCycles(HALF);
      for (int f = 1; f <= nFalls; f++) begin
         if (expBits.size() > 0) begin
            e = expBits.pop_front();
            checkOutput($sformatf("%s_line_f%0d", tag, f), ps2Dat, e);
         end else begin
            checkOutput($sformatf("%s_sb_empty_f%0d", tag, f), 0, 1);
         end
         if (f == 11 && doAck) devDat = 1'b0;
         devClk = 1'b0;
         waitCycles(HALF);
         devClk = 1'b1;
         waitCycles(HALF);
      end
      devDat = 1'b1;
   endtask

   task automatic checkPulses(input string tag, input int d0, input int n0, input int t0,
                              input int ed, input int en, input int et);
      checkOutput({tag, "_done_cnt"}, doneCnt - d0, ed);
      checkOutput({tag, "_nack_cnt"}, nackCnt - n0, en);
      checkOutput({tag, "_tmo_cnt"},  tmoCnt - t0,  et);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int            d0, n0, t0, k;
      logic [7:0]    parityBytes[2];
      parityBytes[0] = 8'h01;
      parityBytes[1] = 8'h00;

      // Reset state
      waitCycles(2);
      checkOutput("rst_ready", txReady, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_oe", {clkOe, datOe}, 2'b00);
      checkOutput("rst_pulses", {done, nack, tmo}, 3'b000);
      enable = 1'b0;
      #1 checkOutput("rst_ready_en0", txReady, 0);
      enable = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      waitCycles(2);

      // Basic send with ACK
      d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
      applyStimulus(8'hED);
      checkInhibit("ed");
      runDevice("ed", 11, 1'b1);
      waitCycles(10);
      checkPulses("ed", d0, n0, t0, 1, 0, 0);
      checkOutput("ed_idle_busy", busy, 0);

      // Parity bits for 0x01 and 0x00
      foreach (parityBytes[i]) begin
         d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
         applyStimulus(parityBytes[i]);
         checkInhibit($sformatf("par%0d", i));
         runDevice($sformatf("par%0d", i), 11, 1'b1);
         waitCycles(10);
         checkPulses($sformatf("par%0d", i), d0, n0, t0, 1, 0, 0);
      end

      // NACK: device leaves data high at the 11th fall
      d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
      applyStimulus(8'h5A);
      checkInhibit("nack");
      runDevice("nack", 11, 1'b0);
      waitCycles(10);
      checkPulses("nack", d0, n0, t0, 0, 1, 0);
      checkOutput("nack_next_ready_oe", afterNack, 3'b100);

      // Timeout: device stops after 4 falls
      d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
      applyStimulus(8'h3C);
      checkInhibit("tmo");
      runDevice("tmo", 4, 1'b1);
      k = 0;
      while (tmoCnt == t0 && k < 400) begin
         @(negedge clock);
         k++;
      end
      waitCycles(2);
      checkPulses("tmo", d0, n0, t0, 0, 0, 1);
      // TIMEOUT timed SEND cycles follow RTS; the pulse lands in the cycle after them
      checkOutput("tmo_latency", tmoCycle - rtsCycle, TIMEOUT + 1);
      checkOutput("tmo_next_ready_oe", afterTmo, 3'b100);
      expBits.delete();

      // Abort by dropping enable during SEND
      d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
      applyStimulus(8'h77);
      checkInhibit("abort");
      runDevice("abort", 2, 1'b1);
      enable = 1'b0;
      @(negedge clock);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_oe", {clkOe, datOe}, 2'b00);
      checkOutput("abort_ready_en0", txReady, 0);
      waitCycles(5);
      checkPulses("abort", d0, n0, t0, 0, 0, 0);
      enable = 1'b1;
      expBits.delete();

      // Asynchronous reset during INHIBIT
      d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
      applyStimulus(8'h99);
      waitCycles(3);
      checkOutput("rstmid_inhibit_oe", {clkOe, datOe}, 2'b10);
      reset = 1'b1;
      #1;
      checkOutput("rstmid_oe", {clkOe, datOe}, 2'b00);
      checkOutput("rstmid_busy", busy, 0);
      @(negedge clock);
      reset = 1'b0;
      waitCycles(3);
      checkPulses("rstmid", d0, n0, t0, 0, 0, 0);
      expBits.delete();

      // Busy handling: 0xAA held valid through the 0xF4 transfer
      d0 = doneCnt; n0 = nackCnt; t0 = tmoCnt;
      @(negedge clock);
      txValid = 1'b1;
      txData  = 8'hF4;
      @(posedge clock);
      pushFrame(8'hF4);
      #1 txData = 8'hAA;
      monBusy = 1'b1;
      checkInhibit("f4");
      runDevice("f4", 11, 1'b1);
      k = 0;
      while (!done && k < 200) begin
         @(negedge clock);
         k++;
      end
      checkOutput("f4_done_seen", done, 1);
      checkOutput("aa_ready_at_done", txReady, 1);
      monBusy = 1'b0;
      @(posedge clock);
      pushFrame(8'hAA);
      #1 txValid = 1'b0;
      checkOutput("f4_busy_drop", busyDrop, 0);
      checkOutput("f4_ready_early", readyEarly, 0);
      checkInhibit("aa");
      runDevice("aa", 11, 1'b1);
      waitCycles(10);
      checkPulses("busy", d0, n0, t0, 2, 0, 0);
      checkOutput("sb_drained", expBits.size(), 0);
      checkOutput("pulse_width", longPulse, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
